// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-side controller.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours port 0 on a tie, 1 favours port 1
  logic ptr_q, ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      if (&req) gnt = ptr_q ? 2'b10 : 2'b01;
      else      gnt = req;
    end
    if (|gnt) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write port controller: post-reset zero-fill, then round-robin
// writeback arbitration between the ALU (port 0) and load (port 1) paths.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_addr,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  input  logic              freeze,
  output logic              w,
  output logic [REG_AW-1:0] write_addr,
  output logic [XLEN-1:0]   write_val,
  output logic              init_done
);

  wb_state_t         state_q, state_d;
  logic [REG_AW:0]   init_cnt_q, init_cnt_d;
  logic              w_q, w_d;
  logic [REG_AW-1:0] write_addr_q, write_addr_d;
  logic [XLEN-1:0]   write_val_q, write_val_d;
  logic              arb_en;
  logic [1:0]        gnt;

  assign arb_en = (state_q == ST_RUN) && !freeze;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({mem_valid, alu_valid}),
    .gnt   (gnt)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    w_d          = 1'b0;
    write_addr_d = write_addr_q;
    write_val_d  = write_val_q;
    if (state_q == ST_INIT) begin
      // The extra counter bit marks the idle cycle after the last fill write.
      if (init_cnt_q[REG_AW]) begin
        state_d = ST_RUN;
      end else begin
        w_d          = 1'b1;
        write_addr_d = init_cnt_q[REG_AW-1:0];
        write_val_d  = '0;
        init_cnt_d   = init_cnt_q + {{REG_AW{1'b0}}, 1'b1};
      end
    end else begin
      if (gnt[0]) begin
        write_addr_d = alu_addr;
        write_val_d  = alu_data;
        w_d          = (alu_addr != '0);
      end else if (gnt[1]) begin
        write_addr_d = mem_addr;
        write_val_d  = mem_data;
        w_d          = (mem_addr != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      w_q          <= 1'b0;
      write_addr_q <= '0;
      write_val_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      w_q          <= w_d;
      write_addr_q <= write_addr_d;
      write_val_q  <= write_val_d;
    end
  end

  assign alu_ready  = gnt[0];
  assign mem_ready  = gnt[1];
  assign w          = w_q;
  assign write_addr = write_addr_q;
  assign write_val  = write_val_q;
  assign init_done  = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: zero-fill, arbitration table, freeze and mid-stream reset.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, mem_valid, freeze;
  logic [REG_AW-1:0] alu_addr, mem_addr;
  logic [XLEN-1:0]   alu_data, mem_data;
  logic              alu_ready, mem_ready, w, init_done;
  logic [REG_AW-1:0] write_addr;
  logic [XLEN-1:0]   write_val;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .freeze     (freeze),
    .w          (w),
    .write_addr (write_addr),
    .write_val  (write_val),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              av;
    logic [REG_AW-1:0] aa;
    logic [XLEN-1:0]   ad;
    logic              mv;
    logic [REG_AW-1:0] ma;
    logic [XLEN-1:0]   md;
    logic              frz;
    logic              e_ar;
    logic              e_mr;
    logic              e_w;
    logic [REG_AW-1:0] e_addr;
    logic [XLEN-1:0]   e_val;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Walks the 32 fill writes plus the terminal cycle; readys must stay low throughout.
  task automatic check_fill();
    for (int i = 0; i < NUM_REGS; i++) begin
      @(posedge clk); #1;
      chk($sformatf("fill_w[%0d]", i), 32'(w), 32'd1);
      chk($sformatf("fill_addr[%0d]", i), 32'(write_addr), 32'(i));
      chk($sformatf("fill_val[%0d]", i), write_val, 32'd0);
      chk($sformatf("fill_rdy[%0d]", i), {30'd0, mem_ready, alu_ready}, 32'd0);
      chk($sformatf("fill_done[%0d]", i), 32'(init_done), 32'd0);
    end
    @(posedge clk); #1;
    chk("fill_end_w", 32'(w), 32'd0);
    chk("fill_end_done", 32'(init_done), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h12345678};
    vecs[3]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[4]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    vecs[5]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[6]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44};
    vecs[7]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44};
    vecs[8]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h44};
    vecs[9]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,       1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
    vecs[10] = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
    vecs[11] = '{1'b1, 5'd8, 32'h88,       1'b1, 5'd9, 32'h99,       1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};

    rst_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hFFFF_FFFF;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hEEEE_EEEE;
    freeze = 1'b1;
    #3;
    chk("rst_w", 32'(w), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_val", write_val, 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_rdy", {30'd0, mem_ready, alu_ready}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    check_fill();
    alu_valid = 1'b0; mem_valid = 1'b0; freeze = 1'b0;

    for (int v = 0; v < 12; v++) begin
      alu_valid = vecs[v].av; alu_addr = vecs[v].aa; alu_data = vecs[v].ad;
      mem_valid = vecs[v].mv; mem_addr = vecs[v].ma; mem_data = vecs[v].md;
      freeze = vecs[v].frz;
      #1;
      chk($sformatf("v%0d_alu_ready", v), 32'(alu_ready), 32'(vecs[v].e_ar));
      chk($sformatf("v%0d_mem_ready", v), 32'(mem_ready), 32'(vecs[v].e_mr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_w", v), 32'(w), 32'(vecs[v].e_w));
      chk($sformatf("v%0d_addr", v), 32'(write_addr), 32'(vecs[v].e_addr));
      chk($sformatf("v%0d_val", v), write_val, vecs[v].e_val);
    end

    // Request accepted combinationally, then reset lands before the granting edge.
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hAAAA5555;
    mem_valid = 1'b0; freeze = 1'b0;
    #1;
    chk("pre_rst_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_w", 32'(w), 32'd0);
    chk("async_rst_done", 32'(init_done), 32'd0);
    chk("async_rst_rdy", 32'(alu_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_fill();
    chk("post_fill_alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    chk("post_fill_w", 32'(w), 32'd1);
    chk("post_fill_addr", 32'(write_addr), 32'd10);
    chk("post_fill_val", write_val, 32'hAAAA5555);
    alu_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_fill_idle_w", 32'(w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
